fifo_push_arb: RTL and testbench
================================

FIFO_PUSH_ARB -- requirements
Module: fifo_push_arb

Interface
REQ-001 SHALL have parameter DW, default 8, meaning data width of requester and FIFO write data.
REQ-002 SHALL have parameter CW, default 8, meaning width of the per-requester grant counters.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req0  input  1  requester 0 wants to push; held until ack0.
REQ-006 SHALL have port data0  input  DW  requester 0 write data; stable while req0 high.
REQ-007 SHALL have port req1  input  1  requester 1 wants to push; held until ack1.
REQ-008 SHALL have port data1  input  DW  requester 1 write data; stable while req1 high.
REQ-009 SHALL have port full  input  1  FIFO full flag.
REQ-010 SHALL have port push  output  1  FIFO push strobe, registered.
REQ-011 SHALL have port w_data  output  DW  FIFO write data, registered.
REQ-012 SHALL have port ack0  output  1  one-cycle grant acknowledge to requester 0, registered.
REQ-013 SHALL have port ack1  output  1  one-cycle grant acknowledge to requester 1, registered.
REQ-014 SHALL have port cnt0  output  CW  saturating count of grants to requester 0.
REQ-015 SHALL have port cnt1  output  CW  saturating count of grants to requester 1.

Function
REQ-016 SHALL implement a two-state FSM: ARB and PUSH.
REQ-017 In ARB, full=0 and at least one req high: SHALL pick a winner, load w_data, and set push=1 and the winner's ack=1 at the edge, then move to PUSH.
REQ-018 In ARB, full=1 or no req: SHALL stay in ARB with push=0, ack0=0, ack1=0, and w_data unchanged.
REQ-019 In PUSH: SHALL clear push and both acks at the next edge, then return to ARB unconditionally.
REQ-020 push and ack pulses SHALL be exactly one cycle and coincident; ack0 and ack1 SHALL never be high together.
REQ-021 Peak throughput SHALL be one push every 2 cycles, so full sampled in ARB already reflects the previous push.
REQ-022 Single request: SHALL grant that requester regardless of priority pointer.
REQ-023 Both requests: SHALL grant the requester indicated by pointer prio (0 or 1).
REQ-024 After any grant, prio SHALL point to the non-granted requester (round-robin); with no grant, prio SHALL hold.
REQ-025 A request arriving while in PUSH SHALL be considered in the following ARB cycle and never lost.
REQ-026 Requester SHALL drop or replace its req/data at the edge ending the ack cycle; the arbiter SHALL not re-sample req during PUSH.
REQ-027 cnt0/cnt1 SHALL increment on the edge that sets the matching ack and saturate at 2^CW-1 (no wrap).
REQ-028 full rising while in PUSH SHALL not cancel the push already issued.

Reset
REQ-029 On rst=1, SHALL go immediately to ARB with push=0, ack0=0, ack1=0, w_data=0, cnt0=0, cnt1=0, prio=0, independent of clk.
REQ-030 Reset asserted during PUSH SHALL abort the pulse immediately; no push SHALL issue until after rst is released and a new ARB decision is made.
REQ-031 First ARB decision SHALL occur at the first rising edge after rst deasserts.

Verification
REQ-032 Reset: rst=1 mid-pulse -> push, ack0, ack1, cnt0, cnt1 = 0 within the same cycle, before the next edge.
REQ-033 Single requester: req0=1, data0=8'hA5 held, full=0 -> push/ack0 pulse with w_data=8'hA5 once every 2 cycles; cnt0 after 4 grants = 4.
REQ-034 Contention: req0=req1=1 continuously, data0=8'h11, data1=8'h22 -> w_data sequence 11,22,11,22; ack0/ack1 alternate; never both high.
REQ-035 Full stall: full=1 with req1=1 for 10 cycles -> no push or ack; full=0 -> push with data1 on next edge; prio unchanged during stall.
REQ-036 Scoreboard: random req/data from both requesters into the team's 16-deep fifo with random pop -> every acked word popped in grant order, no loss or duplication, no push while full=1.
REQ-037 Saturation: CW=4 with 20 grants to requester 0 -> cnt0 = 15 and holds.

Source files
------------

// File: rtl/fifo_push_arb.sv
// Two-requester round-robin push arbiter in front of a FIFO write port.
// One grant every two cycles; push, ack and data are all registered.
module fifo_push_arb #(
    parameter int DW = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic [DW-1:0] data0,
    input  logic          req1,
    input  logic [DW-1:0] data1,
    input  logic          full,
    output logic          push,
    output logic [DW-1:0] w_data,
    output logic          ack0,
    output logic          ack1,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1
);

    typedef enum logic {ARB, PUSH} state_t;

    localparam logic [CW-1:0] CMAX = '1;

    state_t        state, state_nx;
    logic          prio, prio_nx;
    logic          push_nx, ack0_nx, ack1_nx;
    logic [DW-1:0] w_data_nx;
    logic [CW-1:0] cnt0_nx, cnt1_nx;
    logic          win0, win1;

    // prio=0 favours requester 0 under contention
    assign win0 = req0 && (!req1 || !prio);
    assign win1 = req1 && (!req0 || prio);

    always_comb begin
        state_nx  = state;
        prio_nx   = prio;
        push_nx   = 1'b0;
        ack0_nx   = 1'b0;
        ack1_nx   = 1'b0;
        w_data_nx = w_data;
        cnt0_nx   = cnt0;
        cnt1_nx   = cnt1;
        unique case (state)
            ARB: begin
                if (!full && (win0 || win1)) begin
                    state_nx  = PUSH;
                    push_nx   = 1'b1;
                    ack0_nx   = win0;
                    ack1_nx   = win1;
                    w_data_nx = win0 ? data0 : data1;
                    prio_nx   = win0;
                    if (win0 && cnt0 != CMAX)
                        cnt0_nx = cnt0 + 1'b1;
                    if (win1 && cnt1 != CMAX)
                        cnt1_nx = cnt1 + 1'b1;
                end
            end
            PUSH: begin
                state_nx = ARB;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ARB;
            prio   <= 1'b0;
            push   <= 1'b0;
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            w_data <= '0;
            cnt0   <= '0;
            cnt1   <= '0;
        end else begin
            state  <= state_nx;
            prio   <= prio_nx;
            push   <= push_nx;
            ack0   <= ack0_nx;
            ack1   <= ack1_nx;
            w_data <= w_data_nx;
            cnt0   <= cnt0_nx;
            cnt1   <= cnt1_nx;
        end
    end

endmodule

// File: tb/tb_fifo_push_arb.sv
// Directed and scoreboarded bench for fifo_push_arb.
// A second instance with 4-bit counters shares the stimulus.
module tb_fifo_push_arb;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic       full = 1'b0;
    logic [7:0] data0 = 8'h00;
    logic [7:0] data1 = 8'h00;

    logic       push, ack0, ack1;
    logic [7:0] w_data, cnt0, cnt1;
    logic       push_s, ack0_s, ack1_s;
    logic [7:0] w_data_s;
    logic [3:0] cnt0_s, cnt1_s;

    int checks = 0;
    int errors = 0;

    logic [7:0] fq[$];
    logic [7:0] eq[$];

    always #5 clk = ~clk;

    fifo_push_arb dut (
        .clk(clk), .rst(rst),
        .req0(req0), .data0(data0),
        .req1(req1), .data1(data1),
        .full(full), .push(push), .w_data(w_data),
        .ack0(ack0), .ack1(ack1),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    fifo_push_arb #(.DW(8), .CW(4)) dut_s (
        .clk(clk), .rst(rst),
        .req0(req0), .data0(data0),
        .req1(req1), .data1(data1),
        .full(full), .push(push_s), .w_data(w_data_s),
        .ack0(ack0_s), .ack1(ack1_s),
        .cnt0(cnt0_s), .cnt1(cnt1_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One cycle of the random phase: observe, model FIFO, move requesters
    task automatic rnd_step(input bit drive);
        logic [7:0] d;
        @(negedge clk);
        chk("rnd_onehot", {31'd0, ack0 & ack1}, 0);
        chk("rnd_push_ack", {31'd0, push}, {31'd0, ack0 | ack1});
        if (push) begin
            d = ack0 ? data0 : data1;
            chk("rnd_no_full", (fq.size() < 16) ? 1 : 0, 1);
            chk("rnd_wdata", {24'd0, w_data}, {24'd0, d});
            eq.push_back(d);
            fq.push_back(w_data);
        end
        if (fq.size() > 0 && (!drive || $urandom_range(0, 2) == 0)) begin
            if (eq.size() > 0)
                chk("rnd_order", {24'd0, fq.pop_front()},
                    {24'd0, eq.pop_front()});
            else
                chk("rnd_extra", fq.size(), 0);
        end
        full = (fq.size() >= 16);
        if (drive) begin
            if (ack0 || !req0) begin
                req0  = 1'($urandom_range(0, 1));
                data0 = 8'($urandom);
            end
            if (ack1 || !req1) begin
                req1  = 1'($urandom_range(0, 1));
                data1 = 8'($urandom);
            end
        end
    endtask

    initial begin
        // asynchronous reset before any clock edge
        #2 rst = 1'b1;
        #1;
        chk("rst_push", {31'd0, push}, 0);
        chk("rst_ack0", {31'd0, ack0}, 0);
        chk("rst_ack1", {31'd0, ack1}, 0);
        chk("rst_wdata", {24'd0, w_data}, 0);
        chk("rst_cnt0", {24'd0, cnt0}, 0);
        chk("rst_cnt1", {24'd0, cnt1}, 0);
        chk("rst_s_out", {20'd0, push_s, ack0_s, ack1_s, w_data_s, cnt1_s}, 0);

        // single requester 0
        @(negedge clk);
        rst = 1'b0;
        req0 = 1'b1;
        data0 = 8'hA5;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("s0_push", {31'd0, push}, 1);
            chk("s0_ack0", {31'd0, ack0}, 1);
            chk("s0_ack1", {31'd0, ack1}, 0);
            chk("s0_wdata", {24'd0, w_data}, 32'hA5);
            chk("s0_cnt0", {24'd0, cnt0}, i);
            chk("s0_cnt0_s", {28'd0, cnt0_s}, i);
            if (i == 4)
                req0 = 1'b0;
            @(negedge clk);
            chk("s0_gap", {30'd0, push, ack0}, 0);
        end

        // full stall with requester 1
        full = 1'b1;
        req1 = 1'b1;
        data1 = 8'h5C;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_idle", {30'd0, push, ack1}, 0);
        end
        chk("stall_wdata", {24'd0, w_data}, 32'hA5);
        full = 1'b0;
        @(negedge clk);
        chk("stall_push", {31'd0, push}, 1);
        chk("stall_ack", {30'd0, ack0, ack1}, 1);
        chk("stall_data", {24'd0, w_data}, 32'h5C);
        chk("stall_cnt1", {24'd0, cnt1}, 1);
        req1 = 1'b0;
        @(negedge clk);
        chk("stall_gap", {31'd0, push}, 0);

        // contention, prio now points at requester 0
        req0 = 1'b1;
        req1 = 1'b1;
        data0 = 8'h11;
        data1 = 8'h22;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rr_push", {31'd0, push}, 1);
            chk("rr_data", {24'd0, w_data}, (k % 2 == 0) ? 32'h11 : 32'h22);
            chk("rr_acks", {30'd0, ack0, ack1}, (k % 2 == 0) ? 2 : 1);
            @(negedge clk);
            chk("rr_gap", {29'd0, push, ack0, ack1}, 0);
        end
        chk("rr_cnt0", {24'd0, cnt0}, 6);
        chk("rr_cnt1", {24'd0, cnt1}, 3);

        // stall with both requesting must not move prio
        full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("st2_idle", {31'd0, push}, 0);
        end
        full = 1'b0;
        @(negedge clk);
        chk("st2_acks", {30'd0, ack0, ack1}, 2);
        chk("st2_data", {24'd0, w_data}, 32'h11);
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        chk("st2_gap", {31'd0, push}, 0);

        // reset in the middle of a push pulse
        req0 = 1'b1;
        data0 = 8'h44;
        @(negedge clk);
        chk("mr_ack0", {31'd0, ack0}, 1);
        chk("mr_data", {24'd0, w_data}, 32'h44);
        chk("mr_cnt0", {24'd0, cnt0}, 8);
        #1 rst = 1'b1;
        #1;
        chk("mr_push", {31'd0, push}, 0);
        chk("mr_acks", {30'd0, ack0, ack1}, 0);
        chk("mr_wdata", {24'd0, w_data}, 0);
        chk("mr_cnts", {16'd0, cnt0, cnt1}, 0);
        chk("mr_cnt0_s", {28'd0, cnt0_s}, 0);
        data0 = 8'h11;
        req1 = 1'b1;
        data1 = 8'h22;
        @(negedge clk);
        chk("mr_held", {31'd0, push}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("mr_first", {30'd0, ack0, ack1}, 2);
        chk("mr_fdata", {24'd0, w_data}, 32'h11);
        chk("mr_fcnt", {16'd0, cnt0, cnt1}, 32'h0100);
        req1 = 1'b0;
        @(negedge clk);
        chk("mr_gap", {31'd0, push}, 0);

        // saturation of the 4-bit instance
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            chk("sat_ack0", {31'd0, ack0_s}, 1);
            chk("sat_cnt0_s", {28'd0, cnt0_s}, (i + 1 > 15) ? 15 : i + 1);
            if (i == 20)
                req0 = 1'b0;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        chk("sat_hold", {28'd0, cnt0_s}, 15);
        chk("sat_cnt0", {24'd0, cnt0}, 21);

        // random traffic into a 16-deep FIFO model
        for (int n = 0; n < 600; n++)
            rnd_step(1'b1);
        req0 = 1'b0;
        req1 = 1'b0;
        for (int n = 0; n < 40; n++)
            rnd_step(1'b0);
        chk("rnd_drain_exp", eq.size(), 0);
        chk("rnd_drain_fifo", fq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
